// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit back end.
package lcd_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT, INIT_A, INIT_B, INIT_C, INIT_D, CFG,
        IDLE, SEND_HI, GAP, SEND_LO, POST_WAIT
    } lcd_state_t;

    typedef enum logic [2:0] {
        W_IDLE, W_SETUP, W_HIGH, W_HOLD, W_DONE
    } nib_state_t;

    localparam logic [7:0] CFG_FUNCSET = 8'h28;
    localparam logic [7:0] CFG_ENTRY   = 8'h06;
    localparam logic [7:0] CFG_DISPON  = 8'h0C;
    localparam logic [7:0] CFG_CLEAR   = 8'h01;

    localparam logic [3:0] NIB_INIT3 = 4'h3;
    localparam logic [3:0] NIB_INIT2 = 4'h2;

    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return CFG_FUNCSET;
            2'd1:    return CFG_ENTRY;
            2'd2:    return CFG_DISPON;
            default: return CFG_CLEAR;
        endcase
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) need the long settle time.
    function automatic logic is_slow_cmd(input logic [7:0] b, input logic rs);
        return !rs && (b[7:2] == 6'd0) && (b != 8'd0);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives one nibble onto the panel bus: setup, E strobe, hold, then a done pulse.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EHIGH = 12,
    parameter int unsigned T_HOLD  = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iStart,
    input  logic [3:0] iNibble,
    input  logic       iRS,
    output logic       oE,
    output logic       oRS,
    output logic [3:0] oData,
    output logic       oDone
);

    localparam int unsigned MAXT = max_u(max_u(T_SETUP, T_EHIGH), T_HOLD);
    localparam int unsigned CW   = $clog2(MAXT) + 1;

    nib_state_t    st;
    logic [CW-1:0] cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            st    <= W_IDLE;
            cnt   <= '0;
            oE    <= 1'b0;
            oRS   <= 1'b0;
            oData <= '0;
            oDone <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (st)
                W_IDLE, W_DONE: begin
                    st <= W_IDLE;
                    if (iStart) begin
                        oRS   <= iRS;
                        oData <= iNibble;
                        cnt   <= CW'(T_SETUP - 1);
                        st    <= W_SETUP;
                    end
                end
                W_SETUP: begin
                    if (cnt == '0) begin
                        oE  <= 1'b1;
                        cnt <= CW'(T_EHIGH - 1);
                        st  <= W_HIGH;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                W_HIGH: begin
                    if (cnt == '0) begin
                        oE  <= 1'b0;
                        cnt <= CW'(T_HOLD - 1);
                        st  <= W_HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                W_HOLD: begin
                    if (cnt == '0) begin
                        oDone <= 1'b1;
                        st    <= W_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: st <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_controller.sv
// HD44780 4-bit back end for the LCD instruction: power-on init, config, then
// one byte per handshake with oReady as the BNLCD busy flag.
module lcd_controller
    import lcd_pkg::*;
#(
    parameter int unsigned T_POWERUP = 750000,
    parameter int unsigned T_INIT1   = 205000,
    parameter int unsigned T_INIT2   = 5000,
    parameter int unsigned T_SETUP   = 2,
    parameter int unsigned T_EHIGH   = 12,
    parameter int unsigned T_HOLD    = 1,
    parameter int unsigned T_GAP     = 50,
    parameter int unsigned T_SHORT   = 2000,
    parameter int unsigned T_LONG    = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iWrite,
    output logic       oReady,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic [3:0] oLCD_Data
);

    localparam int unsigned MAXT = max_u(max_u(max_u(T_POWERUP, T_INIT1), max_u(T_INIT2, T_GAP)),
                                         max_u(T_SHORT, T_LONG));
    localparam int unsigned CW   = $clog2(MAXT) + 1;

    lcd_state_t    state, init_next;
    logic [CW-1:0] cnt, init_wait;
    logic          armed, start_q, rs_q, in_cfg;
    logic [7:0]    byte_q, cfg_cur;
    logic [3:0]    nib_q, init_nib;
    logic [1:0]    cfg_idx;
    logic          accept, wr_start, wr_rs, wr_done;
    logic [3:0]    wr_nib;

    // The high nibble of a CPU byte starts on the accepting edge itself so the
    // busy period matches the documented latency; all other nibbles use start_q.
    assign accept   = (state == IDLE) && iWrite;
    assign wr_start = accept || start_q;
    assign wr_nib   = accept ? iData[7:4] : nib_q;
    assign wr_rs    = accept ? iRS : rs_q;
    assign cfg_cur  = cfg_byte(cfg_idx);
    assign oLCD_RW  = 1'b0;

    always_comb begin
        init_wait = CW'(T_SHORT - 1);
        init_next = CFG;
        init_nib  = NIB_INIT3;
        case (state)
            INIT_A: begin init_wait = CW'(T_INIT1 - 1); init_next = INIT_B; end
            INIT_B: begin init_wait = CW'(T_INIT2 - 1); init_next = INIT_C; end
            INIT_C: begin init_next = INIT_D; init_nib = NIB_INIT2; end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= PWR_WAIT;
            cnt     <= '0;
            armed   <= 1'b0;
            start_q <= 1'b0;
            rs_q    <= 1'b0;
            in_cfg  <= 1'b0;
            byte_q  <= '0;
            nib_q   <= '0;
            cfg_idx <= '0;
            oReady  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state)
                // Counter is zero out of reset, so the first cycle loads it.
                PWR_WAIT: begin
                    if (!armed) begin
                        armed <= 1'b1;
                        cnt   <= CW'(T_POWERUP - 2);
                    end else if (cnt == '0) begin
                        armed   <= 1'b0;
                        state   <= INIT_A;
                        start_q <= 1'b1;
                        nib_q   <= NIB_INIT3;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                INIT_A, INIT_B, INIT_C, INIT_D: begin
                    if (!armed) begin
                        if (wr_done) begin
                            armed <= 1'b1;
                            cnt   <= init_wait;
                        end
                    end else if (cnt == '0) begin
                        armed <= 1'b0;
                        state <= init_next;
                        if (init_next != CFG) begin
                            start_q <= 1'b1;
                            nib_q   <= init_nib;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                CFG: begin
                    byte_q  <= cfg_cur;
                    rs_q    <= 1'b0;
                    nib_q   <= cfg_cur[7:4];
                    start_q <= 1'b1;
                    in_cfg  <= 1'b1;
                    state   <= SEND_HI;
                end
                IDLE: begin
                    if (iWrite) begin
                        byte_q <= iData;
                        rs_q   <= iRS;
                        in_cfg <= 1'b0;
                        oReady <= 1'b0;
                        state  <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (wr_done) begin
                        cnt   <= CW'(T_GAP - 1);
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        start_q <= 1'b1;
                        nib_q   <= byte_q[3:0];
                        state   <= SEND_LO;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SEND_LO: begin
                    if (wr_done) begin
                        cnt   <= is_slow_cmd(byte_q, rs_q) ? CW'(T_LONG - 1) : CW'(T_SHORT - 1);
                        state <= POST_WAIT;
                    end
                end
                POST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (in_cfg && cfg_idx != 2'd3) begin
                        cfg_idx <= cfg_idx + 2'd1;
                        state   <= CFG;
                    end else begin
                        in_cfg <= 1'b0;
                        oReady <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

    lcd_nibble_writer #(
        .T_SETUP (T_SETUP),
        .T_EHIGH (T_EHIGH),
        .T_HOLD  (T_HOLD)
    ) u_writer (
        .Clock   (Clock),
        .Reset   (Reset),
        .iStart  (wr_start),
        .iNibble (wr_nib),
        .iRS     (wr_rs),
        .oE      (oLCD_E),
        .oRS     (oLCD_RS),
        .oData   (oLCD_Data),
        .oDone   (wr_done)
    );

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller with shortened timing parameters.
module tb_lcd_controller;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] iData = 8'h00;
    logic       iRS = 1'b0;
    logic       iWrite = 1'b0;
    logic       oReady, oLCD_E, oLCD_RS, oLCD_RW;
    logic [3:0] oLCD_Data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic rst_q = 1'b1;

    logic [3:0] nibs[$];
    logic       rss[$];
    int         rises[$];
    int         rise_at = 0;
    logic       e_prev = 1'b0, rs_prev = 1'b0;
    logic [3:0] d_prev = 4'h0;
    int         rw_bad = 0, stab_bad = 0, width_bad = 0;

    localparam logic [3:0] INIT_EXP [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                              4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};

    always #5 Clock = ~Clock;

    lcd_controller #(
        .T_POWERUP (20),
        .T_INIT1   (10),
        .T_INIT2   (6),
        .T_SETUP   (2),
        .T_EHIGH   (4),
        .T_HOLD    (1),
        .T_GAP     (3),
        .T_SHORT   (8),
        .T_LONG    (40)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .iData     (iData),
        .iRS       (iRS),
        .iWrite    (iWrite),
        .oReady    (oReady),
        .oLCD_E    (oLCD_E),
        .oLCD_RS   (oLCD_RS),
        .oLCD_RW   (oLCD_RW),
        .oLCD_Data (oLCD_Data)
    );

    always @(posedge Clock) begin
        cyc   <= cyc + 1;
        rst_q <= Reset;
    end

    // Bus monitor: records each E rise and flags bus changes while E is high.
    always @(negedge Clock) begin
        if (oLCD_RW !== 1'b0) rw_bad <= rw_bad + 1;
        if (e_prev && !rst_q && (oLCD_Data != d_prev || oLCD_RS != rs_prev))
            stab_bad <= stab_bad + 1;
        if (oLCD_E && !e_prev) begin
            nibs.push_back(oLCD_Data);
            rss.push_back(oLCD_RS);
            rises.push_back(cyc);
            rise_at <= cyc;
        end
        if (!oLCD_E && e_prev && !rst_q && (cyc - rise_at != 4))
            width_bad <= width_bad + 1;
        e_prev  <= oLCD_E;
        d_prev  <= oLCD_Data;
        rs_prev <= oLCD_RS;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_init();
        int bad = 0;
        int n = 0;
        int base;
        base = nibs.size();
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (oReady || oLCD_E) bad++;
        end
        check_eq("pwrup_quiet", bad, 0);
        while (!oReady && n < 3000) begin
            @(negedge Clock);
            n++;
        end
        check_eq("init_ready", oReady, 1);
        check_eq("init_count", nibs.size() - base, 12);
        if (nibs.size() >= base + 12) begin
            for (int i = 0; i < 12; i++) begin
                check_eq($sformatf("init_nib%0d", i), nibs[base+i], INIT_EXP[i]);
                check_eq($sformatf("init_rs%0d", i), rss[base+i], 0);
            end
            check_eq("init_post_long", cyc - rises[nibs.size()-1], 46);
        end
        check_eq("init_e_width", width_bad, 0);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic rs, input bit poke, output int busy);
        iData  = d;
        iRS    = rs;
        iWrite = 1'b1;
        @(negedge Clock);
        iWrite = 1'b0;
        iData  = 8'h4F;
        iRS    = ~rs;
        busy   = 0;
        while (!oReady && busy < 500) begin
            busy++;
            iWrite = poke && (busy == 5 || busy == 15);
            @(negedge Clock);
        end
        iWrite = 1'b0;
    endtask

    task automatic check_byte(input string tag, input int base, input logic [7:0] d, input logic rs);
        check_eq({tag, "_count"}, nibs.size() - base, 2);
        if (nibs.size() >= base + 2) begin
            check_eq({tag, "_hi"}, nibs[base], d[7:4]);
            check_eq({tag, "_lo"}, nibs[base+1], d[3:0]);
            check_eq({tag, "_rs_hi"}, rss[base], rs);
            check_eq({tag, "_rs_lo"}, rss[base+1], rs);
            check_eq({tag, "_spacing"}, rises[base+1] - rises[base], 12);
        end
    endtask

    initial begin
        int busy, base, n;

        repeat (3) @(negedge Clock);
        check_eq("rst_ready", oReady, 0);
        check_eq("rst_e", oLCD_E, 0);
        check_eq("rst_rs", oLCD_RS, 0);
        check_eq("rst_data", oLCD_Data, 0);
        Reset = 1'b0;
        run_init();

        base = nibs.size();
        send_byte(8'h48, 1'b1, 1'b0, busy);
        check_eq("busy_H", busy, 28);
        check_byte("byte_H", base, 8'h48, 1'b1);

        base = nibs.size();
        send_byte(8'h01, 1'b0, 1'b0, busy);
        check_eq("busy_clear", busy, 60);
        check_byte("byte_clear", base, 8'h01, 1'b0);

        base = nibs.size();
        send_byte(8'h80, 1'b0, 1'b0, busy);
        check_eq("busy_ddram", busy, 28);
        check_byte("byte_ddram", base, 8'h80, 1'b0);

        base = nibs.size();
        send_byte(8'h41, 1'b1, 1'b1, busy);
        check_eq("busy_poke", busy, 28);
        repeat (30) @(negedge Clock);
        check_byte("byte_poke", base, 8'h41, 1'b1);
        check_eq("poke_idle_ready", oReady, 1);

        base = nibs.size();
        iData  = 8'h55;
        iRS    = 1'b1;
        iWrite = 1'b1;
        for (int b = 0; b < 2; b++) begin
            n = 0;
            @(negedge Clock);
            while (!oReady && n < 500) begin
                n++;
                @(negedge Clock);
            end
            check_eq($sformatf("busy_b2b%0d", b), n, 28);
        end
        iWrite = 1'b0;
        check_eq("b2b_count", nibs.size() - base, 4);
        if (nibs.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("b2b_nib%0d", i), nibs[base+i], 4'h5);
                check_eq($sformatf("b2b_rs%0d", i), rss[base+i], 1);
            end
        end

        repeat (3) @(negedge Clock);
        base   = nibs.size();
        iData  = 8'h48;
        iRS    = 1'b1;
        iWrite = 1'b1;
        @(negedge Clock);
        iWrite = 1'b0;
        n = 0;
        while (!(nibs.size() >= base + 2 && oLCD_E) && n < 200) begin
            @(negedge Clock);
            n++;
        end
        check_eq("abort_reach_lo_e", oLCD_E, 1);
        Reset = 1'b1;
        @(negedge Clock);
        check_eq("abort_e", oLCD_E, 0);
        check_eq("abort_ready", oReady, 0);
        check_eq("abort_data", oLCD_Data, 0);
        Reset = 1'b0;
        run_init();

        check_eq("rw_low", rw_bad, 0);
        check_eq("bus_stable_e_high", stab_bad, 0);
        check_eq("e_width_all", width_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
